// File: rtl/led_seq_timer.sv
// LED sequence timer: three debounced push buttons drive an IDLE/RUN/PAUSE FSM
// that steps an N_LED-bit value (down, up or rotate) once per TICK_CYCLES clocks.
//
// state    | meaning
// ST_IDLE  | stopped; tick counter cleared, val holds the initial value for mode
// ST_RUN   | tick counter advancing, val steps on each tick
// ST_PAUSE | tick counter and val frozen, partial period preserved
module led_seq_timer #(
  parameter int TICK_CYCLES     = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int N_LED           = 4,
  parameter bit LED_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start_n,
  input  logic             btn_stop_n,
  input  logic             btn_mode_n,
  output logic [N_LED-1:0] LEDs,
  output logic [1:0]       mode,
  output logic             running,
  output logic             tick
);

  localparam int TCNT_W = $clog2(TICK_CYCLES);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] MODE_DOWN   = 2'd0;
  localparam logic [1:0] MODE_UP     = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;

  // Button index: 0 = start/pause, 1 = stop, 2 = mode
  logic [2:0]      btn_raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      acc;
  logic [2:0]      acc_d;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  assign btn_raw = {btn_mode_n, btn_stop_n, btn_start_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      acc   <= '1;
      acc_d <= '1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      acc_d <= acc;
      // Press fires one cycle after the accepted level falls; releases are silent
      press <= acc_d & ~acc;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          acc[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic start_ev;
  logic stop_ev;
  logic mode_ev;

  assign start_ev = press[0];
  assign stop_ev  = press[1];
  assign mode_ev  = press[2];

  function automatic logic [N_LED-1:0] init_val(input logic [1:0] m);
    logic [N_LED-1:0] v;
    case (m)
      MODE_UP:     v = '0;
      MODE_ROTATE: v = {{(N_LED-1){1'b0}}, 1'b1};
      default:     v = '1;
    endcase
    return v;
  endfunction

  function automatic logic [N_LED-1:0] step_val(input logic [N_LED-1:0] v,
                                                input logic [1:0]       m);
    logic [N_LED-1:0] r;
    case (m)
      MODE_UP:     r = v + 1'b1;
      MODE_ROTATE: r = {v[N_LED-2:0], v[N_LED-1]};
      default:     r = v - 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_DOWN: r = MODE_UP;
      MODE_UP:   r = MODE_ROTATE;
      default:   r = MODE_DOWN;
    endcase
    return r;
  endfunction

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [1:0]        mode_q;
  logic [1:0]        mode_nx;
  logic [N_LED-1:0]  val;
  logic [N_LED-1:0]  val_nx;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_nx;

  assign tick = (state == ST_RUN) && (tcnt == TCNT_LAST);

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    val_nx   = val;
    tcnt_nx  = tcnt;
    case (state)
      ST_IDLE: begin
        tcnt_nx = '0;
        // Mode applies first so a same-cycle start runs from the new initial value
        if (mode_ev) begin
          mode_nx = next_mode(mode_q);
          val_nx  = init_val(mode_nx);
        end
        if (start_ev) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        tcnt_nx = (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;
        if (tick) begin
          val_nx = step_val(val, mode_q);
        end
        if (stop_ev) begin
          state_nx = ST_IDLE;
          val_nx   = init_val(mode_q);
          tcnt_nx  = '0;
        end else if (start_ev) begin
          state_nx = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          state_nx = ST_IDLE;
          val_nx   = init_val(mode_q);
          tcnt_nx  = '0;
        end else if (start_ev) begin
          state_nx = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        val_nx   = init_val(mode_q);
        tcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_DOWN;
      val     <= '1;
      tcnt    <= '0;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      mode_q  <= mode_nx;
      val     <= val_nx;
      tcnt    <= tcnt_nx;
      running <= (state_nx == ST_RUN);
    end
  end

  assign mode = mode_q;
  assign LEDs = LED_ACTIVE_LOW ? ~val : val;

endmodule

// File: tb/tb_led_seq_timer.sv
// Directed bench for led_seq_timer: table of run scenarios plus hand-written
// sequences for glitches, pause/resume, stop/start collisions and async reset.
module tb_led_seq_timer;

  localparam int TICK = 10;
  localparam int DEB  = 4;
  localparam int NL   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_start_n = 1'b1;
  logic       btn_stop_n  = 1'b1;
  logic       btn_mode_n  = 1'b1;
  logic [3:0] leds;
  logic [1:0] mode;
  logic       running;
  logic       tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  led_seq_timer #(
    .TICK_CYCLES(TICK),
    .DEBOUNCE_CYCLES(DEB),
    .N_LED(NL),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_start_n(btn_start_n),
    .btn_stop_n(btn_stop_n),
    .btn_mode_n(btn_mode_n),
    .LEDs(leds),
    .mode(mode),
    .running(running),
    .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         n_mode;
    int         n_ticks;
    logic [1:0] exp_mode;
    logic [3:0] exp_init;
    logic [3:0] exp_final;
  } row_t;

  row_t rows [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [3:0] model);
    logic [3:0] exp_led;
    exp_led = ~model;
    chk(name, int'(leds), int'(exp_led));
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic logic [3:0] ref_step(input logic [3:0] v, input logic [1:0] m);
    int x;
    x = int'(v);
    case (m)
      2'd0:    x = (x + 15) % 16;
      2'd1:    x = (x + 1) % 16;
      default: x = (x == 8) ? 1 : x * 2;
    endcase
    return 4'(x);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    btn_start_n = 1'b1;
    btn_stop_n  = 1'b1;
    btn_mode_n  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode_n = 1'b0;
    repeat (8) @(negedge clk);
    btn_mode_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_running(input string name, input logic lvl);
    int i;
    for (i = 0; i < 15; i++) begin
      @(negedge clk);
      if (running == lvl) break;
    end
    chk(name, int'(running), int'(lvl));
  endtask

  task automatic start_run(input string name, output int c0);
    btn_start_n = 1'b0;
    wait_running(name, 1'b1);
    c0 = cyc;
    btn_start_n = 1'b1;
  endtask

  task automatic wait_tick(input string name, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int c0, at, prev, n, h, ticks_seen;
    logic [3:0] model, frozen;

    rows[0] = '{0, 16, 2'd0, 4'b1111, 4'b1111};
    rows[1] = '{1, 17, 2'd1, 4'b0000, 4'b0001};
    rows[2] = '{2,  4, 2'd2, 4'b0001, 4'b0001};
    rows[3] = '{3,  3, 2'd0, 4'b1111, 4'b1100};

    #2 rst = 1'b1;
    #1;
    chk("rst_leds", int'(leds), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_tick", int'(tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Glitches of 3 and 2 cycles must not be accepted
    btn_start_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_start_n = 1'b1;
    repeat (10) @(negedge clk);
    btn_start_n = 1'b0;
    repeat (2) @(negedge clk);
    btn_start_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("glitch_running", int'(running), 0);
    chk("glitch_leds", int'(leds), 0);
    chk("glitch_mode", int'(mode), 0);

    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int m = 0; m < rows[r].n_mode; m++) press_mode();
      chk($sformatf("row%0d_mode", r), int'(mode), int'(rows[r].exp_mode));
      chk_val($sformatf("row%0d_init", r), rows[r].exp_init);
      start_run($sformatf("row%0d_run", r), c0);
      model = rows[r].exp_init;
      prev = c0;
      for (int t = 0; t < rows[r].n_ticks; t++) begin
        wait_tick($sformatf("row%0d_tick%0d", r, t), 25, at);
        if (at >= 0) begin
          chk($sformatf("row%0d_period%0d", r, t), at - prev, (t == 0) ? TICK - 1 : TICK);
          prev = at;
        end
        model = ref_step(model, rows[r].exp_mode);
        @(negedge clk);
        chk_val($sformatf("row%0d_val%0d", r, t), model);
      end
      chk_val($sformatf("row%0d_final", r), rows[r].exp_final);
    end

    // Mode press during RUN in ROTATE is ignored
    do_reset();
    press_mode();
    press_mode();
    start_run("rotmode_run", c0);
    model = 4'b0001;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) btn_mode_n = 1'b0;
      if (i == 10) btn_mode_n = 1'b1;
      @(negedge clk);
      if (n == 1) begin
        chk_val($sformatf("rotmode_val%0d", i), model);
        n = 0;
      end
      if (tick) begin
        model = ref_step(model, 2'd2);
        n = 1;
      end
    end
    chk("rotmode_mode", int'(mode), 2);
    chk("rotmode_running", int'(running), 1);

    // Mode and start in the same IDLE cycle
    do_reset();
    btn_start_n = 1'b0;
    btn_mode_n  = 1'b0;
    wait_running("ms_run", 1'b1);
    btn_start_n = 1'b1;
    btn_mode_n  = 1'b1;
    chk("ms_mode", int'(mode), 1);
    chk_val("ms_val", 4'b0000);

    // Pause with counter at 6, hold, resume: tick on 4th running cycle
    do_reset();
    start_run("pause_run", c0);
    wait_tick("pause_t1", 15, at);
    model = 4'b1110;
    @(negedge clk);
    chk_val("pause_v1", model);
    repeat (8) @(negedge clk);
    btn_start_n = 1'b0;
    h = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!running) break;
      if (tick) begin
        model = ref_step(model, 2'd0);
        h = 0;
      end else begin
        h++;
      end
    end
    chk("pause_stopped", int'(running), 0);
    btn_start_n = 1'b1;
    chk("pause_h", h, 6);
    chk_val("pause_val", model);
    frozen = leds;
    ticks_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick) ticks_seen++;
    end
    chk("pause_no_tick", ticks_seen, 0);
    chk("pause_frozen", int'(leds), int'(frozen));
    btn_start_n = 1'b0;
    wait_running("resume_run", 1'b1);
    btn_start_n = 1'b1;
    n = 1;
    while (!tick && n < 15) begin
      @(negedge clk);
      n++;
    end
    chk("resume_gap", n, 4);
    model = ref_step(model, 2'd0);
    @(negedge clk);
    chk_val("resume_val", model);

    // Start and stop in the same cycle from RUN: stop wins
    do_reset();
    start_run("ss_run", c0);
    wait_tick("ss_t1", 15, at);
    @(negedge clk);
    btn_start_n = 1'b0;
    btn_stop_n  = 1'b0;
    wait_running("ss_stopped", 1'b0);
    btn_start_n = 1'b1;
    btn_stop_n  = 1'b1;
    chk_val("ss_val", 4'b1111);
    repeat (12) @(negedge clk);
    chk("ss_idle", int'(running), 0);
    start_run("ss_rerun", c0);
    wait_tick("ss_t2", 15, at);
    if (at >= 0) chk("ss_first_tick", at - c0, TICK - 1);

    // Async reset mid-RUN in ROTATE
    do_reset();
    press_mode();
    press_mode();
    start_run("rr_run", c0);
    wait_tick("rr_t1", 15, at);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rr_mode", int'(mode), 0);
    chk("rr_running", int'(running), 0);
    chk("rr_leds", int'(leds), 0);
    chk("rr_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rr_stays_idle", int'(running), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
